// File: rtl/level_sensor_conditioner.sv
// Float-sensor front end: 2-flop sync, per-bit debounce, thermometer-code check,
// held output code with change strobe and sticky fault.

module lsc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic db_o
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Counter only advances while the synced bit disagrees; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_i != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = ~db_q;
      else                  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;
endmodule

module level_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FAULT_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw_s,
  input  logic       clear_fault,
  output logic [2:0] s,
  output logic       s_changed,
  output logic       fault
);
  localparam int             FCW      = $clog2(FAULT_CYCLES) + 1;
  localparam logic [FCW-1:0] FLT_MAX  = FCW'(FAULT_CYCLES - 1);
  localparam logic [1:0]     ST_OK      = 2'd0;
  localparam logic [1:0]     ST_SUSPECT = 2'd1;
  localparam logic [1:0]     ST_FAULT   = 2'd2;

  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     db;
  logic           db_valid;
  logic [2:0]     s_q, s_d;
  logic           chg_q, chg_d;
  logic [1:0]     state_q, state_d;
  logic [FCW-1:0] inv_q, inv_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_db
    lsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (reset),
      .sync_i (sync2_q[b]),
      .db_o   (db[b])
    );
  end

  always_comb begin
    unique case (db)
      3'b000, 3'b001, 3'b011, 3'b111: db_valid = 1'b1;
      default:                        db_valid = 1'b0;
    endcase
  end

  // Output only ever loads valid codes, so s stays a thermometer code.
  always_comb begin
    s_d   = s_q;
    chg_d = 1'b0;
    if (db_valid && (db != s_q)) begin
      s_d   = db;
      chg_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    unique case (state_q)
      ST_OK: begin
        if (!db_valid) begin
          inv_d   = FCW'(1);
          state_d = (FAULT_CYCLES == 1) ? ST_FAULT : ST_SUSPECT;
        end
      end
      ST_SUSPECT: begin
        if (db_valid) begin
          state_d = ST_OK;
          inv_d   = '0;
        end else if (inv_q >= FLT_MAX) begin
          state_d = ST_FAULT;
        end else begin
          inv_d = inv_q + FCW'(1);
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          if (db_valid) begin
            state_d = ST_OK;
            inv_d   = '0;
          end else begin
            state_d = ST_SUSPECT;
            inv_d   = FCW'(1);
          end
        end
      end
      default: begin
        state_d = ST_OK;
        inv_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= '0;
      chg_q   <= 1'b0;
      state_q <= ST_OK;
      inv_q   <= '0;
    end else begin
      s_q     <= s_d;
      chg_q   <= chg_d;
      state_q <= state_d;
      inv_q   <= inv_d;
    end
  end

  assign s         = s_q;
  assign s_changed = chg_q;
  assign fault     = (state_q == ST_FAULT);
endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed bench for level_sensor_conditioner with default parameters.
module tb_level_sensor_conditioner;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] raw_s;
  logic       clear_fault;
  logic [2:0] s;
  logic       s_changed;
  logic       fault;
  int tests = 0;
  int fails = 0;

  level_sensor_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .raw_s       (raw_s),
    .clear_fault (clear_fault),
    .s           (s),
    .s_changed   (s_changed),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tests++; if (s !== 3'b000) begin fails++; $display("FAIL reset_s got %b exp 000", s); end
    tests++; if (s_changed !== 1'b0) begin fails++; $display("FAIL reset_chg got %b exp 0", s_changed); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b exp 0", fault); end
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_clean_rise;
    raw_s = 3'b001;
    tick(6);
    tests++; if (s !== 3'b000) begin fails++; $display("FAIL rise_early got %b exp 000", s); end
    tick(1);
    tests++; if (s !== 3'b001 || s_changed !== 1'b1)
      begin fails++; $display("FAIL rise_update got s=%b chg=%b exp s=001 chg=1", s, s_changed); end
    tick(1);
    tests++; if (s_changed !== 1'b0) begin fails++; $display("FAIL rise_pulse got %b exp 0", s_changed); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL rise_fault got %b exp 0", fault); end
  endtask

  task automatic test_glitch;
    bit seen = 1'b0;
    raw_s = 3'b011;
    tick(10);
    tests++; if (s !== 3'b011) begin fails++; $display("FAIL glitch_pre got %b exp 011", s); end
    raw_s = 3'b111;
    tick(3);
    raw_s = 3'b011;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (s_changed) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0 || s !== 3'b011)
      begin fails++; $display("FAIL glitch3 got s=%b pulse=%b exp s=011 pulse=0", s, seen); end
    raw_s = 3'b111;
    tick(4);
    raw_s = 3'b011;
    tick(2);
    tests++; if (s !== 3'b011) begin fails++; $display("FAIL glitch4_early got %b exp 011", s); end
    tick(1);
    tests++; if (s !== 3'b111 || s_changed !== 1'b1)
      begin fails++; $display("FAIL glitch4 got s=%b chg=%b exp s=111 chg=1", s, s_changed); end
    tick(12);
    tests++; if (s !== 3'b011) begin fails++; $display("FAIL glitch4_back got %b exp 011", s); end
    raw_s = 3'b001;
    tick(12);
    tests++; if (s !== 3'b001) begin fails++; $display("FAIL glitch_post got %b exp 001", s); end
  endtask

  task automatic test_invalid;
    bit moved = 1'b0;
    raw_s = 3'b100;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (s !== 3'b001) moved = 1'b1;
      if (i == 13) begin
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL inv_fault_early got %b exp 0", fault); end
      end
      if (i == 14) begin
        tests++; if (fault !== 1'b1) begin fails++; $display("FAIL inv_fault_rise got %b exp 1", fault); end
      end
    end
    tests++; if (moved !== 1'b0) begin fails++; $display("FAIL inv_hold got moved=%b exp 0", moved); end
    raw_s = 3'b001;
    tick(12);
    tests++; if (fault !== 1'b1 || s !== 3'b001)
      begin fails++; $display("FAIL inv_sticky got fault=%b s=%b exp fault=1 s=001", fault, s); end
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL inv_clear got %b exp 0", fault); end
  endtask

  task automatic test_clear_invalid;
    raw_s = 3'b101;
    tick(16);
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL ci_fault got %b exp 1", fault); end
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL ci_drop got %b exp 0", fault); end
    tick(6);
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL ci_early got %b exp 0", fault); end
    tick(1);
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL ci_reassert got %b exp 1", fault); end
    raw_s = 3'b000;
    tick(10);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    tests++; if (fault !== 1'b0 || s !== 3'b000)
      begin fails++; $display("FAIL ci_recover got fault=%b s=%b exp fault=0 s=000", fault, s); end
  endtask

  task automatic test_multibit;
    int pulses = 0;
    raw_s = 3'b111;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (s_changed) pulses++;
      if (i == 7) begin
        tests++; if (s !== 3'b111) begin fails++; $display("FAIL mb_s got %b exp 111", s); end
      end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL mb_pulses got %0d exp 1", pulses); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL mb_fault got %b exp 0", fault); end
    reset = 1'b1;
    #1;
    tests++; if (s !== 3'b000) begin fails++; $display("FAIL mb_async_reset got %b exp 000", s); end
    raw_s = 3'b000;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid;
    raw_s = 3'b001;
    tick(2);
    reset = 1'b1;
    #1;
    tests++; if (s !== 3'b000 || s_changed !== 1'b0 || fault !== 1'b0)
      begin fails++; $display("FAIL rm_async got s=%b chg=%b fault=%b exp 0 0 0", s, s_changed, fault); end
    tick(2);
    reset = 1'b0;
    tick(6);
    tests++; if (s !== 3'b000) begin fails++; $display("FAIL rm_early got %b exp 000", s); end
    tick(1);
    tests++; if (s !== 3'b001 || s_changed !== 1'b1)
      begin fails++; $display("FAIL rm_update got s=%b chg=%b exp s=001 chg=1", s, s_changed); end
  endtask

  initial begin
    reset       = 1'b1;
    raw_s       = 3'b000;
    clear_fault = 1'b0;
    #2;
    test_reset;
    test_clean_rise;
    test_glitch;
    test_invalid;
    test_clear_invalid;
    test_multibit;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/level_sensor_conditioner.md
# level_sensor_conditioner

Front-end conditioner for the reservoir float sensors. It synchronises and debounces the three raw float-switch lines and enforces thermometer-code consistency. It delivers a clean 3-bit level code `s` to the downstream flow-rate controller, with a change strobe and a sticky sensor-fault flag. Invalid codes never reach `s`; the last valid code is held instead.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised bit must differ before its debounced value flips. Range ≥1.
- `FAULT_CYCLES`, default 8: consecutive invalid-code cycles before `fault` sets. Range ≥1.
- `clk` in, 1 bit: single clock; all state is on the rising edge.
- `reset` in, 1 bit: asynchronous, active-high; clears all state immediately.
- `raw_s` in, 3 bits: raw float switches, asynchronous to `clk`. Bit 0 is the lowest sensor.
- `clear_fault` in, 1 bit: synchronous request to clear a sticky fault.
- `s` out, 3 bits: conditioned level code. Always one of 000, 001, 011, 111.
- `s_changed` out, 1 bit: one-cycle pulse in the first cycle `s` shows a new value.
- `fault` out, 1 bit: sticky sensor-inconsistency flag.

## Operation
- **Reset values:** `s`=000, `s_changed`=0, `fault`=0. Synchroniser flops, debounced bits, all counters = 0. Checker state = OK.
- **Synchroniser:** two flops per bit, no reset-time sampling.
- **Debounce:**
  - One counter per bit, width clog2(DEBOUNCE_CYCLES)+1.
  - Synced bit == debounced bit: counter ← 0.
  - Bits differ and counter == DEBOUNCE_CYCLES-1: debounced bit flips and counter ← 0.
  - Bits differ otherwise: counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never flips the debounced bit.
- **Validity:** the debounced vector `db` is valid iff it is 000, 001, 011 or 111.
- **Output register:**
  - `db` valid and ≠ `s`: `s` ← `db` and `s_changed` ← 1.
  - Otherwise `s` holds and `s_changed` ← 0.
- **Checker FSM:**
  - **OK:** `db` invalid → SUSPECT, with invalid counter ← 1. If FAULT_CYCLES==1, go directly to FAULT instead.
  - **SUSPECT:**
    - `db` valid → OK, counter ← 0.
    - `db` invalid and counter == FAULT_CYCLES-1 → FAULT.
    - `db` invalid otherwise → counter increments.
  - **FAULT:** `fault`=1. `s` still tracks valid `db` codes.
    - `clear_fault` and `db` valid → OK, counter ← 0.
    - `clear_fault` and `db` invalid → SUSPECT, counter ← 1.
    - No `clear_fault` → stay in FAULT.
- **`fault` output:** registered; equals (state == FAULT).
- **`clear_fault`** outside FAULT has no effect.

## Timing
- **Latency:**
  - Let edge E0 be the first edge that samples a changed, thereafter-stable `raw_s` bit.
  - The debounced bit flips at edge E0+DEBOUNCE_CYCLES+1.
  - `s` and `s_changed` update at edge E0+DEBOUNCE_CYCLES+2. With the default of 4, that is edge E0+6.
  - `s_changed` is high for exactly the one cycle following that edge.
- **Simultaneous bit changes:**
  - Bits debounce independently, so a multi-bit transition may pass through intermediate codes.
  - Valid intermediates (e.g. 001→011→111) each produce their own `s_changed` pulse.
  - Invalid intermediates hold `s` and advance the invalid counter.
- **Fault timing:** `fault` rises at the edge ending the FAULT_CYCLES-th consecutive cycle with `db` invalid.
- **Fault clear:** `fault` falls at the edge that samples `clear_fault`=1 with `db` valid.
- **Reset mid-operation:** outputs go to their reset values asynchronously. Any partial debounce count and the fault state are discarded. After release, the first update obeys the full latency above.
- **Output behaviour:** no combinational path from any input to any output.

## Test plan
- **Clean rise:** from reset, `raw_s`=001 held stable from edge E0.
  - `s`=001 and `s_changed`=1 after edge E0+6.
  - `s_changed`=0 on the next cycle.
  - `fault` stays 0 throughout.
- **Glitch reject:** with `s`=011, pulse `raw_s`[2] high for 3 cycles.
  - `s` stays 011, no `s_changed` pulse.
  - Repeat with 4 cycles: `s`=111 after the full latency.
- **Invalid code:** with `s`=001, hold `raw_s`=100 for 20 cycles.
  - `s` stays 001.
  - `fault` rises exactly 8 cycles after debounced `db` becomes 100.
  - `fault` stays high after `raw_s` returns to 001 until `clear_fault` is pulsed.
- **Clear while invalid:** in FAULT with `db`=101, pulse `clear_fault` for one cycle.
  - `fault` drops for exactly one edge; state goes to SUSPECT.
  - `fault` re-asserts after 7 more invalid cycles.
- **Multi-bit step:** `raw_s` goes 000→111 on all bits at once.
  - A single `s`=111 update with one `s_changed` pulse.
  - `fault`=0.
- **Reset mid-debounce:** assert `reset` 2 cycles after `raw_s` goes 000→001.
  - Outputs return to 0 immediately.
  - After release with `raw_s` still 001, `s`=001 appears at the full latency measured from the first post-release sampling edge.
